// File: rtl/eth_rx_hdr_strip.sv
// Ethernet RX header stripper: registers the 14-byte header and re-aligns the payload stream.
// Optional statistics counters are enabled by defining ETH_RX_HDR_STRIP_STATS_EN.
module eth_rx_hdr_strip #(
    parameter int DATA_W    = 512,
    parameter int HDR_BYTES = 14,
    parameter int PAD_W     = $clog2(DATA_W / 8) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mac_eth_format_rx_val,
    input  logic [DATA_W-1:0]    mac_eth_format_rx_data,
    input  logic                 mac_eth_format_rx_last,
    input  logic [PAD_W-1:0]     mac_eth_format_rx_padbytes,
    output logic                 eth_format_mac_rx_rdy,
    output logic                 eth_format_eth_rx_out_hdr_val,
    output logic [111:0]         eth_format_eth_rx_out_hdr,
    input  logic                 eth_rx_out_eth_format_hdr_rdy,
    output logic                 eth_format_eth_rx_out_data_val,
    output logic [DATA_W-1:0]    eth_format_eth_rx_out_data,
    output logic                 eth_format_eth_rx_out_data_last,
    output logic [PAD_W-1:0]     eth_format_eth_rx_out_padbytes,
    input  logic                 eth_rx_out_eth_format_data_rdy
`ifdef ETH_RX_HDR_STRIP_STATS_EN
   ,output logic [31:0]          stat_frame_cnt,
    output logic [31:0]          stat_runt_cnt
`endif
);

    localparam int DATA_BYTES = DATA_W / 8;
    localparam int HDR_W      = HDR_BYTES * 8;
    localparam int HOLD_BYTES = DATA_BYTES - HDR_BYTES;
    localparam int HOLD_W     = HOLD_BYTES * 8;
    localparam logic [PAD_W-1:0] HOLD_PAD = PAD_W'(HOLD_BYTES);
    localparam logic [PAD_W-1:0] HDR_PAD  = PAD_W'(HDR_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_TAIL
    } state_t;

    state_t              state_q, state_d;
    logic                hdr_val_q, hdr_val_d;
    logic [HDR_W-1:0]    hdr_q, hdr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [PAD_W-1:0]    tail_pad_q, tail_pad_d;

    logic [HDR_W-1:0]    in_hi;
    logic [HOLD_W-1:0]   in_lo;
    logic                in_rdy;
    logic                idle_accept;
    logic                runt;
    logic                hdr_load;
    logic                out_val;
    logic                out_last;
    logic [PAD_W-1:0]    out_pad;
    logic [DATA_W-1:0]   out_raw;
    logic [DATA_W-1:0]   out_mask;

    assign in_hi = mac_eth_format_rx_data[DATA_W-1 -: HDR_W];
    assign in_lo = mac_eth_format_rx_data[HOLD_W-1:0];

    always_comb begin
        state_d     = state_q;
        hdr_val_d   = hdr_val_q;
        hdr_d       = hdr_q;
        hold_d      = hold_q;
        tail_pad_d  = tail_pad_q;
        in_rdy      = 1'b0;
        idle_accept = 1'b0;
        runt        = 1'b0;
        out_val     = 1'b0;
        out_last    = 1'b0;
        out_pad     = '0;
        out_raw     = '0;

        if (hdr_val_q && eth_rx_out_eth_format_hdr_rdy) begin
            hdr_val_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                in_rdy      = ~hdr_val_q;
                idle_accept = mac_eth_format_rx_val & ~hdr_val_q;
                runt        = idle_accept & mac_eth_format_rx_last &
                              (mac_eth_format_rx_padbytes > HOLD_PAD);
                if (idle_accept) begin
                    hold_d = in_lo;
                    if (!runt) begin
                        if (mac_eth_format_rx_last) begin
                            tail_pad_d = mac_eth_format_rx_padbytes + HDR_PAD;
                            state_d    = ST_TAIL;
                        end else begin
                            state_d    = ST_PAYLOAD;
                        end
                    end
                end
            end

            ST_PAYLOAD: begin
                out_raw = {hold_q, in_hi};
                out_val = mac_eth_format_rx_val;
                in_rdy  = eth_rx_out_eth_format_data_rdy;
                // A last beat with at most HDR_BYTES valid bytes closes the frame in this beat.
                if (mac_eth_format_rx_last && (mac_eth_format_rx_padbytes >= HOLD_PAD)) begin
                    out_last = 1'b1;
                    out_pad  = mac_eth_format_rx_padbytes - HOLD_PAD;
                end
                if (mac_eth_format_rx_val && eth_rx_out_eth_format_data_rdy) begin
                    if (!mac_eth_format_rx_last) begin
                        hold_d = in_lo;
                    end else if (mac_eth_format_rx_padbytes >= HOLD_PAD) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_d     = in_lo;
                        tail_pad_d = mac_eth_format_rx_padbytes + HDR_PAD;
                        state_d    = ST_TAIL;
                    end
                end
            end

            ST_TAIL: begin
                out_raw  = {hold_q, {HDR_W{1'b0}}};
                out_val  = 1'b1;
                out_last = 1'b1;
                out_pad  = tail_pad_q;
                if (eth_rx_out_eth_format_data_rdy) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        hdr_load = idle_accept & ~runt;
        if (hdr_load) begin
            hdr_d     = in_hi;
            hdr_val_d = 1'b1;
        end

        if (rst) begin
            in_rdy  = 1'b0;
            out_val = 1'b0;
        end
    end

    // Zero every byte position beyond the valid count so pad bytes never leak stale data.
    always_comb begin
        out_mask = '0;
        for (int unsigned i = 0; i < DATA_BYTES; i++) begin
            if ((i + 32'(out_pad)) < 32'(DATA_BYTES)) begin
                out_mask[DATA_W-1-8*i -: 8] = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hdr_val_q  <= 1'b0;
            hdr_q      <= '0;
            hold_q     <= '0;
            tail_pad_q <= '0;
        end else begin
            state_q    <= state_d;
            hdr_val_q  <= hdr_val_d;
            hdr_q      <= hdr_d;
            hold_q     <= hold_d;
            tail_pad_q <= tail_pad_d;
        end
    end

    assign eth_format_mac_rx_rdy            = in_rdy;
    assign eth_format_eth_rx_out_hdr_val    = hdr_val_q;
    assign eth_format_eth_rx_out_hdr        = hdr_q;
    assign eth_format_eth_rx_out_data_val   = out_val;
    assign eth_format_eth_rx_out_data       = out_val ? (out_raw & out_mask) : '0;
    assign eth_format_eth_rx_out_data_last  = out_val & out_last;
    assign eth_format_eth_rx_out_padbytes   = out_val ? out_pad : '0;

`ifdef ETH_RX_HDR_STRIP_STATS_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] runt_cnt_q, runt_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        runt_cnt_d  = runt_cnt_q;
        if (hdr_load && (frame_cnt_q != '1)) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
        end
        if (runt && (runt_cnt_q != '1)) begin
            runt_cnt_d = runt_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            runt_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            runt_cnt_q  <= runt_cnt_d;
        end
    end

    assign stat_frame_cnt = frame_cnt_q;
    assign stat_runt_cnt  = runt_cnt_q;
`else
    // Statistics counters are compiled out; the datapath is identical.
`endif

endmodule

// File: tb/tb_eth_rx_hdr_strip.sv
// Scoreboard bench for eth_rx_hdr_strip: frames are modelled as byte queues, the expected
// header and payload beats are pushed on issue and popped by an independent output monitor.
module tb_eth_rx_hdr_strip;

    localparam int DATA_W = 512;
    localparam int DB     = DATA_W / 8;
    localparam int PAD_W  = $clog2(DB) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_val;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [PAD_W-1:0]  in_pad;
    logic              in_rdy;
    logic              hdr_val;
    logic [111:0]      hdr;
    logic              hdr_rdy;
    logic              data_val;
    logic [DATA_W-1:0] data;
    logic              data_last;
    logic [PAD_W-1:0]  data_pad;
    logic              data_rdy;
`ifdef ETH_RX_HDR_STRIP_STATS_EN
    logic [31:0]       stat_frame_cnt;
    logic [31:0]       stat_runt_cnt;
`endif

    eth_rx_hdr_strip #(.DATA_W(DATA_W)) dut (
        .clk                             (clk),
        .rst                             (rst),
        .mac_eth_format_rx_val           (in_val),
        .mac_eth_format_rx_data          (in_data),
        .mac_eth_format_rx_last          (in_last),
        .mac_eth_format_rx_padbytes      (in_pad),
        .eth_format_mac_rx_rdy           (in_rdy),
        .eth_format_eth_rx_out_hdr_val   (hdr_val),
        .eth_format_eth_rx_out_hdr       (hdr),
        .eth_rx_out_eth_format_hdr_rdy   (hdr_rdy),
        .eth_format_eth_rx_out_data_val  (data_val),
        .eth_format_eth_rx_out_data      (data),
        .eth_format_eth_rx_out_data_last (data_last),
        .eth_format_eth_rx_out_padbytes  (data_pad),
        .eth_rx_out_eth_format_data_rdy  (data_rdy)
`ifdef ETH_RX_HDR_STRIP_STATS_EN
       ,.stat_frame_cnt                  (stat_frame_cnt),
        .stat_runt_cnt                   (stat_runt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [PAD_W-1:0]  pad;
    } beat_t;

    logic [111:0] hdr_exp_q[$];
    beat_t        data_exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           exp_frames = 0;
    int           exp_runts = 0;
    bit           hdr_hold = 1'b0;
    bit           data_hold = 1'b0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Output monitor: randomises the sink ready signals and checks every handshake.
    initial begin
        logic [111:0] eh;
        beat_t        eb;
        hdr_rdy  = 1'b0;
        data_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            hdr_rdy  = hdr_hold  ? 1'b0 : ($urandom_range(0, 3) != 0);
            data_rdy = data_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (!rst) begin
                if (hdr_val && hdr_rdy) begin
                    if (hdr_exp_q.size() == 0) begin
                        chk("hdr_unexpected", 1, 0);
                    end else begin
                        eh = hdr_exp_q.pop_front();
                        chk("hdr", DATA_W'(hdr), DATA_W'(eh));
                    end
                end
                if (data_val && data_rdy) begin
                    if (data_exp_q.size() == 0) begin
                        chk("data_unexpected", 1, 0);
                    end else begin
                        eb = data_exp_q.pop_front();
                        chk("data_bytes", data, eb.data);
                        chk("data_last", DATA_W'(data_last), DATA_W'(eb.last));
                        chk("data_pad", DATA_W'(data_pad), DATA_W'(eb.pad));
                    end
                end
            end
        end
    end

    // Drives one beat and returns at posedge+1 after it is accepted.
    task automatic drive_beat(input logic [DATA_W-1:0] d, input logic l, input logic [PAD_W-1:0] p);
        bit hs;
        in_val  = 1'b1;
        in_data = d;
        in_last = l;
        in_pad  = p;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hs = in_rdy;
            @(posedge clk);
            #1;
            if (hs) begin
                in_val = 1'b0;
                return;
            end
        end
        chk("input_accept_timeout", 0, 1);
        in_val = 1'b0;
    endtask

    // Builds a random frame, queues its expected outputs and sends up to max_beats beats.
    task automatic send_frame(input int len, input bit exp_data, input int max_beats);
        byte unsigned fr[$];
        logic [111:0]      h;
        logic [DATA_W-1:0] d;
        beat_t             b;
        int np, nb, nbo, idx;
        for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
        if (len < 14) begin
            exp_runts++;
        end else begin
            exp_frames++;
            for (int i = 0; i < 14; i++) h[111-8*i -: 8] = fr[i];
            hdr_exp_q.push_back(h);
            np = len - 14;
            if (exp_data) begin
                if (np == 0) begin
                    b.data = '0;
                    b.last = 1'b1;
                    b.pad  = PAD_W'(DB);
                    data_exp_q.push_back(b);
                end else begin
                    nbo = (np + DB - 1) / DB;
                    for (int k = 0; k < nbo; k++) begin
                        b.data = '0;
                        for (int i = 0; i < DB; i++) begin
                            idx = k * DB + i;
                            if (idx < np) b.data[DATA_W-1-8*i -: 8] = fr[14 + idx];
                        end
                        b.last = (k == nbo - 1);
                        b.pad  = b.last ? PAD_W'(nbo * DB - np) : '0;
                        data_exp_q.push_back(b);
                    end
                end
            end
        end
        nb = (len + DB - 1) / DB;
        for (int k = 0; k < nb && k < max_beats; k++) begin
            for (int i = 0; i < DB; i++) begin
                idx = k * DB + i;
                d[DATA_W-1-8*i -: 8] = (idx < len) ? fr[idx] : 8'($urandom);
            end
            if (k == nb - 1) drive_beat(d, 1'b1, PAD_W'(nb * DB - len));
            else             drive_beat(d, 1'b0, PAD_W'($urandom_range(0, DB - 1)));
        end
    endtask

    task automatic wait_drain(input string nm);
        int c;
        c = 0;
        while ((hdr_exp_q.size() != 0 || data_exp_q.size() != 0) && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(nm, DATA_W'(hdr_exp_q.size() + data_exp_q.size()), 0);
    endtask

    int directed_lens[15] = '{60, 138, 84, 14, 10, 78, 128, 64, 65, 13, 15, 1, 114, 192, 200};

    initial begin
        int viol;
        rst     = 1'b1;
        in_val  = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        in_pad  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hdr_val", DATA_W'(hdr_val), 0);
        chk("reset_data_val", DATA_W'(data_val), 0);
        chk("reset_in_rdy", DATA_W'(in_rdy), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_rdy", DATA_W'(in_rdy), 1);

        foreach (directed_lens[i]) send_frame(directed_lens[i], 1'b1, 1000);
        wait_drain("drain_directed");

        // Header sink stalled: the next frame's first beat must wait for the header to be taken.
        hdr_hold = 1'b1;
        send_frame(60, 1'b1, 1000);
        fork
            send_frame(100, 1'b1, 1000);
            begin
                viol = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (in_rdy) viol++;
                end
                chk("stall_rdy_cycles", DATA_W'(viol), 0);
                chk("stall_hdr_held", DATA_W'(hdr_val), 1);
                hdr_hold = 1'b0;
            end
        join
        send_frame(70, 1'b1, 1000);
        wait_drain("drain_stall");

        for (int n = 0; n < 40; n++) send_frame(int'($urandom_range(1, 300)), 1'b1, 1000);
        wait_drain("drain_random");

`ifdef ETH_RX_HDR_STRIP_STATS_EN
        chk("stat_frame_cnt", DATA_W'(stat_frame_cnt), DATA_W'(exp_frames));
        chk("stat_runt_cnt", DATA_W'(stat_runt_cnt), DATA_W'(exp_runts));
`endif

        // Reset in the middle of a payload: only the header of the aborted frame is delivered.
        data_hold = 1'b1;
        send_frame(150, 1'b0, 1);
        in_val  = 1'b1;
        in_last = 1'b0;
        in_data = {DB{8'hA5}};
        wait_drain("drain_abort_hdr");
        @(negedge clk);
        chk("payload_passthrough_val", DATA_W'(data_val), 1);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        in_val = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_hdr_val", DATA_W'(hdr_val), 0);
        chk("midreset_data_val", DATA_W'(data_val), 0);
        chk("midreset_in_rdy", DATA_W'(in_rdy), 0);
        rst       = 1'b0;
        data_hold = 1'b0;
        exp_frames = 0;
        exp_runts  = 0;
        @(posedge clk);
        #1;
        chk("postreset_data_val", DATA_W'(data_val), 0);
        send_frame(100, 1'b1, 1000);
        send_frame(10, 1'b1, 1000);
        send_frame(14, 1'b1, 1000);
        wait_drain("drain_postreset");
`ifdef ETH_RX_HDR_STRIP_STATS_EN
        chk("stat_frame_cnt_postreset", DATA_W'(stat_frame_cnt), DATA_W'(exp_frames));
        chk("stat_runt_cnt_postreset", DATA_W'(stat_runt_cnt), DATA_W'(exp_runts));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
